fpga_robots_game_lock_seq: RTL and testbench

Clock-bring-up sequencer for the game's two-PLL clock generator (32MHz → 52MHz → 65MHz). It runs on the always-present on-board input clock and drives the PLL reset inputs in order. It synchronizes and debounces the asynchronous PLL LOCKED outputs, retries on timeout, and emits a registered `ready` level that replaces the current hard-wired lock indication. Downstream logic in the 65MHz domain resynchronizes `ready` and holds game logic in reset while it is low.

---
 rtl/fpga_robots_game_pkg.sv | 28 ++
 rtl/fpga_robots_game_sync.sv | 34 +++
 rtl/fpga_robots_game_lock_seq.sv | 149 ++++++++++++++
 tb/tb_fpga_robots_game_lock_seq.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_robots_game_pkg.sv
// ----------------------------------------------------------------------------
// fpga_robots_game_pkg : shared state codes and 32MHz default timing (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

package fpga_robots_game_pkg;

   typedef enum logic [2:0] {
      LS_RST_ALL = 3'd0,
      LS_WAIT1   = 3'd1,
      LS_RST2    = 3'd2,
      LS_WAIT2   = 3'd3,
      LS_SETTLE  = 3'd4,
      LS_RUN     = 3'd5
   } lock_state_e;

   localparam int DEF_SYNC_STAGES    = 2;
   localparam int DEF_RST_CYCLES     = 8;
   localparam int DEF_STABLE_CYCLES  = 1024;
   localparam int DEF_TIMEOUT_CYCLES = 65536;
   localparam int DEF_SETTLE_CYCLES  = 256;
   localparam int DEF_CW             = 17;

   localparam logic [3:0] RETRY_MAX  = 4'd15;

endpackage

`default_nettype wire

// File: rtl/fpga_robots_game_sync.sv
// ----------------------------------------------------------------------------
// fpga_robots_game_sync : N-stage single-bit synchronizer (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module fpga_robots_game_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fpga_robots_game_lock_seq.sv
// ----------------------------------------------------------------------------
// fpga_robots_game_lock_seq : two-PLL reset/lock bring-up sequencer (rev 1.0)
// ----------------------------------------------------------------------------
`default_nettype none

module fpga_robots_game_lock_seq
   import fpga_robots_game_pkg::*;
#(
   parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
   parameter int RST_CYCLES     = DEF_RST_CYCLES,
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int CW             = DEF_CW
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lock1,
   input  logic       lock2,
   output logic       pll1_rst,
   output logic       pll2_rst,
   output logic       ready,
   output logic [2:0] state,
   output logic [3:0] retry_count
);

   logic          lock1_s;
   logic          lock2_s;
   lock_state_e   state_q,    state_d;
   logic [CW-1:0] cnt_q,      cnt_d;
   logic [CW-1:0] stab_q,     stab_d;
   logic [3:0]    retry_q,    retry_d;
   logic          pll1_rst_q, pll1_rst_d;
   logic          pll2_rst_q, pll2_rst_d;
   logic          ready_q,    ready_d;
   logic [CW-1:0] cnt_inc;
   logic          lock_loss;
   logic          bump;

   fpga_robots_game_sync #(.STAGES(SYNC_STAGES)) u_sync_lock1 (
      .clk (clk),
      .rst (rst),
      .d   (lock1),
      .q   (lock1_s)
   );

   fpga_robots_game_sync #(.STAGES(SYNC_STAGES)) u_sync_lock2 (
      .clk (clk),
      .rst (rst),
      .d   (lock2),
      .q   (lock2_s)
   );

   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      cnt_inc   = cnt_q + CW'(1);
      cnt_d     = cnt_inc;
      stab_d    = '0;
      bump      = 1'b0;
      // PLL 2 runs from PLL 1, so losing lock1 invalidates everything downstream
      lock_loss = (!lock1_s && (state_q inside {LS_RST2, LS_WAIT2, LS_SETTLE, LS_RUN}))
               || (!lock2_s && (state_q inside {LS_SETTLE, LS_RUN}));

      case (state_q)
         LS_RST_ALL: begin
            if (cnt_inc == CW'(RST_CYCLES)) state_d = LS_WAIT1;
         end
         LS_WAIT1: begin
            stab_d = lock1_s ? stab_q + CW'(1) : '0;
            if (stab_d == CW'(STABLE_CYCLES)) begin
               state_d = LS_RST2;
            end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
               state_d = LS_RST_ALL;
               bump    = 1'b1;
            end
         end
         LS_RST2: begin
            if (cnt_inc == CW'(RST_CYCLES)) state_d = LS_WAIT2;
         end
         LS_WAIT2: begin
            stab_d = lock2_s ? stab_q + CW'(1) : '0;
            if (stab_d == CW'(STABLE_CYCLES)) begin
               state_d = LS_SETTLE;
            end else if (cnt_inc == CW'(TIMEOUT_CYCLES)) begin
               state_d = LS_RST_ALL;
               bump    = 1'b1;
            end
         end
         LS_SETTLE: begin
            if (cnt_inc == CW'(SETTLE_CYCLES)) state_d = LS_RUN;
         end
         LS_RUN: begin
            state_d = LS_RUN;
         end
         default: begin
            state_d = LS_RST_ALL;
         end
      endcase

      if (lock_loss) begin
         state_d = LS_RST_ALL;
         bump    = 1'b1;
      end

      if (bump && (retry_q != RETRY_MAX)) retry_d = retry_q + 4'd1;

      if (state_d != state_q) begin
         cnt_d  = '0;
         stab_d = '0;
      end else if (state_q == LS_RUN) begin
         cnt_d  = cnt_q;
      end

      // Outputs are decoded from the next state so they change with the state register
      pll1_rst_d = (state_d == LS_RST_ALL);
      pll2_rst_d = (state_d inside {LS_RST_ALL, LS_WAIT1, LS_RST2});
      ready_d    = (state_d == LS_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LS_RST_ALL;
         cnt_q      <= '0;
         stab_q     <= '0;
         retry_q    <= '0;
         pll1_rst_q <= 1'b1;
         pll2_rst_q <= 1'b1;
         ready_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         stab_q     <= stab_d;
         retry_q    <= retry_d;
         pll1_rst_q <= pll1_rst_d;
         pll2_rst_q <= pll2_rst_d;
         ready_q    <= ready_d;
      end
   end

   assign pll1_rst    = pll1_rst_q;
   assign pll2_rst    = pll2_rst_q;
   assign ready       = ready_q;
   assign state       = state_q;
   assign retry_count = retry_q;

endmodule

`default_nettype wire

// File: tb/tb_fpga_robots_game_lock_seq.sv
// ----------------------------------------------------------------------------
// tb_fpga_robots_game_lock_seq : scoreboard bench for the PLL lock sequencer
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fpga_robots_game_lock_seq;

   localparam int SYNC = 2;
   localparam int RSTC = 4;
   localparam int STAB = 8;
   localparam int TMO  = 32;
   localparam int SETL = 4;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       lock1 = 1'b0;
   logic       lock2 = 1'b0;
   logic       pll1_rst;
   logic       pll2_rst;
   logic       ready;
   logic [2:0] state;
   logic [3:0] retry_count;

   fpga_robots_game_lock_seq #(
      .SYNC_STAGES    (SYNC),
      .RST_CYCLES     (RSTC),
      .STABLE_CYCLES  (STAB),
      .TIMEOUT_CYCLES (TMO),
      .SETTLE_CYCLES  (SETL),
      .CW             (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .lock1       (lock1),
      .lock2       (lock2),
      .pll1_rst    (pll1_rst),
      .pll2_rst    (pll2_rst),
      .ready       (ready),
      .state       (state),
      .retry_count (retry_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       p1;
      logic       p2;
      logic       rdy;
      logic [3:0] rc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   exp_t mon_obs;
   int   n_total = 0;
   int   n_pass  = 0;

   // Reference model: phase number, edge of phase entry, raw lock history per edge
   int   m_state    = 0;
   int   m_entry    = 0;
   int   m_retry    = 0;
   int   m_last_rst = 0;
   int   k          = 0;
   bit   samp1[$];
   bit   samp2[$];
   int   c1 = 0;
   int   c2 = 0;

   task automatic chk(string name, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // Synchronized lock seen by the sequencer at edge kk: raw sample SYNC edges earlier
   function automatic bit ls(int which, int kk);
      int idx;
      idx = kk - SYNC;
      if (idx <= m_last_rst) return 1'b0;
      return (which == 1) ? samp1[idx] : samp2[idx];
   endfunction

   function automatic int high_run(int which);
      int n;
      n = 0;
      for (int j = k; j > m_entry; j--) begin
         if (!ls(which, j)) break;
         n++;
      end
      return n;
   endfunction

   function automatic void m_step(bit r, bit a, bit b);
      int  nxt;
      bit  bump;
      bit  s1;
      bit  s2;
      samp1.push_back(a);
      samp2.push_back(b);
      if (r) begin
         m_state    = 0;
         m_entry    = k;
         m_retry    = 0;
         m_last_rst = k;
      end else begin
         s1   = ls(1, k);
         s2   = ls(2, k);
         nxt  = m_state;
         bump = 1'b0;
         if ((m_state >= 2 && !s1) || (m_state >= 4 && !s2)) begin
            nxt  = 0;
            bump = 1'b1;
         end else if (m_state == 1 || m_state == 3) begin
            if (high_run(m_state == 1 ? 1 : 2) == STAB) nxt = m_state + 1;
            else if (k - m_entry == TMO) begin
               nxt  = 0;
               bump = 1'b1;
            end
         end else if ((m_state == 0 || m_state == 2) && (k - m_entry == RSTC)) begin
            nxt = m_state + 1;
         end else if (m_state == 4 && (k - m_entry == SETL)) begin
            nxt = 5;
         end
         if (bump && m_retry < 15) m_retry++;
         if (nxt != m_state) begin
            m_state = nxt;
            m_entry = k;
         end
      end
      k++;
   endfunction

   function automatic exp_t m_expect();
      exp_t e;
      e.st  = 3'(m_state);
      e.p1  = (m_state == 0);
      e.p2  = (m_state <= 2);
      e.rdy = (m_state == 5);
      e.rc  = 4'(m_retry);
      return e;
   endfunction

   // One clock of stimulus; returns just after the edge it prepared for
   task automatic step(bit r, bit a, bit b);
      @(negedge clk);
      rst   = r;
      lock1 = a;
      lock2 = b;
      m_step(r, a, b);
      exp_q.push_back(m_expect());
      c1 = (m_state == 0) ? 0 : c1 + 1;
      c2 = (m_state <= 2) ? 0 : c2 + 1;
      @(posedge clk);
      #2;
   endtask

   task automatic steps_until(int target, int d1, int d2, int budget, string name);
      int i;
      i = 0;
      while (int'(state) != target && i < budget) begin
         step(1'b0, c1 >= d1, c2 >= d2);
         i++;
      end
      chk(name, int'(state), target);
   endtask

   task automatic chk_reset_outputs(string tag);
      chk({tag, "_state"}, int'(state), 0);
      chk({tag, "_pll1_rst"}, int'(pll1_rst), 1);
      chk({tag, "_pll2_rst"}, int'(pll2_rst), 1);
      chk({tag, "_ready"}, int'(ready), 0);
      chk({tag, "_retry"}, int'(retry_count), 0);
   endtask

   // Monitor: every edge the DUT presents a new output word
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_obs = {state, pll1_rst, pll2_rst, ready, retry_count};
            n_total++;
            if (mon_obs === mon_e) n_pass++;
            else $display("FAIL outputs t=%0t: got st=%0d p1=%0b p2=%0b rdy=%0b rc=%0d, expected st=%0d p1=%0b p2=%0b rdy=%0b rc=%0d",
                          $time, mon_obs.st, mon_obs.p1, mon_obs.p2, mon_obs.rdy, mon_obs.rc,
                          mon_e.st, mon_e.p1, mon_e.p2, mon_e.rdy, mon_e.rc);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int seen[$];
      int n;
      int cur;
      int runs;
      int first;
      int d1;
      int d2;
      bit a;
      bit b;
      bit r;

      repeat (3) step(1'b1, 1'b0, 1'b0);
      chk_reset_outputs("reset");

      // Nominal bring-up: each lock rises 10 cycles after its PLL reset falls
      seen.push_back(int'(state));
      for (int i = 0; i < 200 && state != 3'd5; i++) begin
         step(1'b0, c1 >= 10, c2 >= 10);
         if (int'(state) != seen[$]) seen.push_back(int'(state));
      end
      chk("nominal_num_states", seen.size(), 6);
      for (int i = 0; i < 6; i++) chk("nominal_state_order", (i < seen.size()) ? seen[i] : -1, i);
      repeat (5) step(1'b0, 1'b1, 1'b1);
      chk("run_ready", int'(ready), 1);
      chk("run_pll1_rst", int'(pll1_rst), 0);
      chk("run_pll2_rst", int'(pll2_rst), 0);
      chk("run_retry", int'(retry_count), 0);

      // One-cycle lock2 drop in RUN: ready falls SYNC+1 edges later
      step(1'b0, 1'b1, 1'b0);
      chk("loss_ready_edge1", int'(ready), 1);
      step(1'b0, 1'b1, 1'b1);
      chk("loss_ready_edge2", int'(ready), 1);
      step(1'b0, 1'b1, 1'b1);
      chk("loss_ready_edge3", int'(ready), 0);
      chk("loss_state", int'(state), 0);
      chk("loss_pll1_rst", int'(pll1_rst), 1);
      chk("loss_pll2_rst", int'(pll2_rst), 1);
      chk("loss_retry", int'(retry_count), 1);

      // Glitch on lock2 in WAIT2 restarts the stability count
      steps_until(3, 10, 1000, 200, "glitch_reach_wait2");
      repeat (3) step(1'b0, 1'b1, 1'b0);
      repeat (5) step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b0);
      n = 0;
      for (int i = 0; i < 40 && state != 3'd4; i++) begin
         step(1'b0, 1'b1, 1'b1);
         n++;
      end
      chk("glitch_settle_delay", n, SYNC + STAB);
      chk("glitch_retry", int'(retry_count), 1);

      // Both locks drop together during SETTLE
      step(1'b0, 1'b0, 1'b0);
      chk("simul_settle_edge1", int'(state), 4);
      step(1'b0, 1'b0, 1'b0);
      chk("simul_settle_edge2", int'(state), 4);
      step(1'b0, 1'b0, 1'b0);
      chk("simul_state", int'(state), 0);
      chk("simul_retry", int'(retry_count), 2);
      step(1'b0, 1'b0, 1'b0);
      chk("simul_retry_after", int'(retry_count), 2);

      // Reset asserted mid-sequence in WAIT2
      steps_until(3, 10, 1000, 200, "midrst_reach_wait2");
      step(1'b1, 1'b1, 1'b0);
      chk_reset_outputs("midrst");

      // Lock1 never arrives: repeated timeouts, retry count saturates
      runs  = 0;
      cur   = 0;
      first = -1;
      repeat (730) begin
         step(1'b0, 1'b0, 1'b0);
         if (state == 3'd1) cur++;
         else if (cur > 0) begin
            if (first < 0) first = cur;
            runs++;
            cur = 0;
         end
      end
      chk("timeout_wait1_cycles", first, TMO);
      chk("timeout_runs", runs, 20);
      chk("timeout_retry_sat", int'(retry_count), 15);

      // Randomized episodes: random lock delays, dropouts and resets
      for (int ep = 0; ep < 12; ep++) begin
         d1 = int'($urandom_range(0, 30));
         d2 = int'($urandom_range(0, 30));
         step(1'b1, 1'b0, 1'b0);
         repeat (250) begin
            a = (c1 >= d1);
            b = (c2 >= d2);
            r = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 79) == 0) a = 1'b0;
            if ($urandom_range(0, 79) == 0) b = 1'b0;
            step(r, a, b);
         end
      end

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
